// File: rtl/mem_wb_pkg.sv
// Shared widths, stall bit positions and the MEM->WB payload for the MEM/WB pipeline register.
package mem_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned STALL_W    = 6;

  localparam int unsigned STALL_MEM  = 4;
  localparam int unsigned STALL_WB   = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [REG_W-1:0]      wdata;
    logic                  whilo;
    logic [REG_W-1:0]      hi;
    logic [REG_W-1:0]      lo;
    logic                  llbit_we;
    logic                  llbit_value;
  } wb_entry_t;

  // An all-zero entry: no GPR, HI/LO or LLbit write.
  function automatic wb_entry_t wb_bubble();
    wb_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO registers with a combinational bypass of the pending WB write.
module hilo_reg
  import mem_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [REG_W-1:0] hi_i,
  input  logic [REG_W-1:0] lo_i,
  output logic [REG_W-1:0] hi_o,
  output logic [REG_W-1:0] lo_o
);

  logic [REG_W-1:0] r_hi;
  logic [REG_W-1:0] r_lo;

  // Commits every cycle the WB stage holds a write, including held cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (we == ENABLE) begin
      r_hi <= hi_i;
      r_lo <= lo_i;
    end
  end

  assign hi_o = (we == ENABLE) ? hi_i : r_hi;
  assign lo_o = (we == ENABLE) ? lo_i : r_lo;

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: drives the GPR write port, owns the LLbit and feeds HI/LO.
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [REG_W-1:0]      mem_wdata,
  input  logic                  mem_whilo,
  input  logic [REG_W-1:0]      mem_hi,
  input  logic [REG_W-1:0]      mem_lo,
  input  logic                  mem_llbit_we,
  input  logic                  mem_llbit_value,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [REG_W-1:0]      wb_wdata,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic                  llbit_o
);

  wb_entry_t r_wb;
  wb_entry_t w_mem;
  logic      r_llbit;
  logic      w_mem_stall;
  logic      w_wb_stall;

  assign w_mem_stall = stall[STALL_MEM];
  assign w_wb_stall  = stall[STALL_WB];

  always_comb begin
    w_mem             = '0;
    w_mem.wd          = mem_wd;
    w_mem.wreg        = mem_wreg;
    w_mem.wdata       = mem_wdata;
    w_mem.whilo       = mem_whilo;
    w_mem.hi          = mem_hi;
    w_mem.lo          = mem_lo;
    w_mem.llbit_we    = mem_llbit_we;
    w_mem.llbit_value = mem_llbit_value;
  end

  // Flush beats any stall; MEM stalled alone inserts a bubble; both stalled holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb <= wb_bubble();
    end else if (flush) begin
      r_wb <= wb_bubble();
    end else if (w_mem_stall && !w_wb_stall) begin
      r_wb <= wb_bubble();
    end else if (!w_mem_stall) begin
      r_wb <= w_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_llbit <= DISABLE;
    end else if (flush) begin
      r_llbit <= DISABLE;
    end else if (r_wb.llbit_we == ENABLE) begin
      r_llbit <= r_wb.llbit_value;
    end
  end

  assign llbit_o = flush ? DISABLE :
                   (r_wb.llbit_we == ENABLE) ? r_wb.llbit_value : r_llbit;

  assign wb_wd    = r_wb.wd;
  assign wb_wreg  = r_wb.wreg;
  assign wb_wdata = r_wb.wdata;

  hilo_reg u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (r_wb.whilo),
    .hi_i (r_wb.hi),
    .lo_i (r_wb.lo),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule
